// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the decimator. Narrowing saturates
// when FIR_DECIM_SAT_EN is defined and wraps (keeps the low bits) otherwise.
package fir_pkg;

  localparam int IN_W_DEF  = 32;
  localparam int OUT_W_DEF = 16;
  localparam int ACC_W     = 64;

  typedef logic signed [IN_W_DEF-1:0] fir_sample_t;
  typedef logic signed [ACC_W-1:0]    wide_t;

  // Round half up, then arithmetic shift; the wide type leaves headroom for the carry.
  function automatic wide_t round_shift(input wide_t x, input int shift);
    if (shift > 0)
      return (x + (wide_t'(1) <<< (shift - 1))) >>> shift;
    else
      return x;
  endfunction

  function automatic wide_t narrow(input wide_t r, input int out_w);
`ifdef FIR_DECIM_SAT_EN
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (out_w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (out_w - 1));
    if (r > hi)
      return hi;
    else if (r < lo)
      return lo;
    else
      return r;
`else
    return r & ((wide_t'(1) <<< out_w) - wide_t'(1));
`endif
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered AXI-Stream buffer: output register plus skid register,
// with a registered ready that is low exactly while the skid entry is occupied.
module axis_skid_buffer #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic             skid_valid_reg, skid_valid_next;
  logic [WIDTH-1:0] skid_data_reg, skid_data_next;
  logic             ready_reg;
  logic             push;

  always_comb begin
    out_valid_next  = out_valid_reg;
    out_data_next   = out_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    push            = in_valid & ready_reg;
    if (!out_valid_reg || out_ready) begin
      // Output slot frees this cycle; the skid entry is older than any new beat.
      if (skid_valid_reg) begin
        out_valid_next  = 1'b1;
        out_data_next   = skid_data_reg;
        skid_valid_next = 1'b0;
      end else begin
        out_valid_next = push;
        if (push)
          out_data_next = in_data;
      end
    end else if (push) begin
      skid_valid_next = 1'b1;
      skid_data_next  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      ready_reg      <= 1'b0;
    end else begin
      out_valid_reg  <= out_valid_next;
      out_data_reg   <= out_data_next;
      skid_valid_reg <= skid_valid_next;
      skid_data_reg  <= skid_data_next;
      ready_reg      <= ~skid_valid_next;
    end
  end

  assign in_ready  = ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

endmodule

// File: rtl/fir_decimate.sv
// AXI-Stream decimator/rescaler: keeps every DECIM-th beat (and every tlast beat),
// rounds and shifts it, narrows to OUT_W (FIR_DECIM_SAT_EN selects saturation).
module fir_decimate
  import fir_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int DECIM = 4,
  parameter int SHIFT = 8
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             s00_axis_tvalid,
  output logic             s00_axis_tready,
  input  logic [IN_W-1:0]  s00_axis_tdata,
  input  logic             s00_axis_tlast,
  output logic             m00_axis_tvalid,
  input  logic             m00_axis_tready,
  output logic [OUT_W-1:0] m00_axis_tdata,
  output logic             m00_axis_tlast
);

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [PW-1:0]    phase_reg, phase_next;
  logic             accept;
  logic             keep;
  wide_t            x_wide, r_wide, n_wide;
  logic [OUT_W-1:0] out_sample;

  assign accept = s00_axis_tvalid & s00_axis_tready;
  assign keep   = accept & ((phase_reg == '0) | s00_axis_tlast);

  always_comb begin
    phase_next = phase_reg;
    if (accept) begin
      // tlast realigns so the next packet starts on a kept beat.
      if (s00_axis_tlast || phase_reg == PW'(DECIM - 1))
        phase_next = '0;
      else
        phase_next = phase_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in)
      phase_reg <= '0;
    else
      phase_reg <= phase_next;
  end

  assign x_wide     = ACC_W'(signed'(s00_axis_tdata));
  assign r_wide     = round_shift(x_wide, SHIFT);
  assign n_wide     = narrow(r_wide, OUT_W);
  assign out_sample = n_wide[OUT_W-1:0];

  logic unused_hi;
  assign unused_hi = ^n_wide[ACC_W-1:OUT_W];

  axis_skid_buffer #(
    .WIDTH(OUT_W + 1)
  ) u_skid (
    .clk      (clk),
    .rst_in   (rst_in),
    .in_valid (keep),
    .in_ready (s00_axis_tready),
    .in_data  ({s00_axis_tlast, out_sample}),
    .out_valid(m00_axis_tvalid),
    .out_ready(m00_axis_tready),
    .out_data ({m00_axis_tlast, m00_axis_tdata})
  );

endmodule

// File: tb/tb_fir_decimate.sv
// Directed bench for fir_decimate: DECIM=4 main instance plus a DECIM=1 instance
// for the throughput case; expected values are hand computed.
module tb_fir_decimate;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [31:0] s_data = '0;
  logic        m_valid, m_last, m_ready = 1'b1;
  logic [15:0] m_data;
  logic        s1_valid = 1'b0, s1_ready;
  logic [31:0] s1_data = '0;
  logic        m1_valid, m1_last, m1_ready = 1'b0;
  logic [15:0] m1_data;

  int tests = 0;
  int fails = 0;
  logic [16:0] q0[$];
  logic [16:0] q1[$];

  always #5 clk = ~clk;

  fir_decimate #(.IN_W(32), .OUT_W(16), .DECIM(4), .SHIFT(8)) dut (
    .clk(clk), .rst_in(rst_in),
    .s00_axis_tvalid(s_valid), .s00_axis_tready(s_ready),
    .s00_axis_tdata(s_data), .s00_axis_tlast(s_last),
    .m00_axis_tvalid(m_valid), .m00_axis_tready(m_ready),
    .m00_axis_tdata(m_data), .m00_axis_tlast(m_last)
  );

  fir_decimate #(.IN_W(32), .OUT_W(16), .DECIM(1), .SHIFT(8)) dut1 (
    .clk(clk), .rst_in(rst_in),
    .s00_axis_tvalid(s1_valid), .s00_axis_tready(s1_ready),
    .s00_axis_tdata(s1_data), .s00_axis_tlast(1'b0),
    .m00_axis_tvalid(m1_valid), .m00_axis_tready(m1_ready),
    .m00_axis_tdata(m1_data), .m00_axis_tlast(m1_last)
  );

  always @(posedge clk) begin
    if (!rst_in && m_valid && m_ready)
      q0.push_back({m_last, m_data});
    if (!rst_in && m1_valid && m1_ready)
      q1.push_back({m1_last, m1_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] qget(input int i);
    if (i < q0.size())
      return q0[i];
    return 17'h1FFFF;
  endfunction

  function automatic logic [16:0] q1get(input int i);
    if (i < q1.size())
      return q1[i];
    return 17'h1FFFF;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send(input logic [31:0] d, input logic l);
    int  n;
    bit  acc;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      acc = s_ready;
      @(negedge clk);
      n++;
    end
    if (!acc)
      chk("send_timeout", 32'd0, 32'd1);
    $display("[TB] beat in data=%08h last=%0b", d, l);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  logic [15:0] exp_pos, exp_neg;
  int  idx;
  bit  acc_prev;
  bit  low_seen;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_s_tready", 32'(s_ready), 32'd0);
    chk("rst_m_tvalid", 32'(m_valid), 32'd0);
    chk("rst_m_tdata",  32'(m_data),  32'd0);
    chk("rst_m_tlast",  32'(m_last),  32'd0);
    rst_in = 1'b0;
    chk("rst_fall_tready_low", 32'(s_ready), 32'd0);
    @(negedge clk);
    chk("rst_fall_tready_high", 32'(s_ready), 32'd1);

    // Plain decimation with one-cycle latency
    for (int k = 0; k < 12; k++) begin
      send(32'(k * 256), 1'b0);
      if (k % 4 == 0) begin
        chk("dec_lat_valid", 32'(m_valid), 32'd1);
        chk("dec_lat_data",  32'(m_data),  32'(k));
      end
    end
    idle(3);
    chk("dec_count", 32'(q0.size()), 32'd3);
    chk("dec_q0", 32'(qget(0)), 32'd0);
    chk("dec_q1", 32'(qget(1)), 32'd4);
    chk("dec_q2", 32'(qget(2)), 32'd8);

    // Rounding (tlast on each beat keeps it regardless of phase)
    send(32'd384, 1'b1);
    chk("rnd_384", 32'(m_data), 32'h0002);
    chk("rnd_384_last", 32'(m_last), 32'd1);
    send(-32'sd384, 1'b1);
    chk("rnd_m384", 32'(m_data), 32'hFFFF);
    send(32'd127, 1'b1);
    chk("rnd_127", 32'(m_data), 32'h0000);
    send(32'd128, 1'b1);
    chk("rnd_128", 32'(m_data), 32'h0001);

    // Narrowing
`ifdef FIR_DECIM_SAT_EN
    exp_pos = 16'h7FFF;
    exp_neg = 16'h8000;
`else
    exp_pos = 16'hFF00;
    exp_neg = 16'h0000;
`endif
    send(32'h7FFF_0000, 1'b1);
    chk("nar_pos", 32'(m_data), 32'(exp_pos));
    send(32'h8000_0000, 1'b1);
    chk("nar_neg", 32'(m_data), 32'(exp_neg));
    idle(2);

    // tlast realignment: 0,2(last),3,7
    q0.delete();
    for (int k = 0; k < 8; k++)
      send(32'(k * 256), (k == 2));
    idle(3);
    chk("tl_count", 32'(q0.size()), 32'd4);
    chk("tl_q0", 32'(qget(0)), {15'd0, 17'h00000});
    chk("tl_q1", 32'(qget(1)), {15'd0, 17'h10002});
    chk("tl_q2", 32'(qget(2)), {15'd0, 17'h00003});
    chk("tl_q3", 32'(qget(3)), {15'd0, 17'h00007});
    send(32'd0, 1'b1);
    idle(2);
    q0.delete();

    // Backpressure: output stalled for the first 6 cycles of a continuous stream
    idx = 0;
    acc_prev = 1'b0;
    low_seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (acc_prev)
        idx++;
      s_valid = (idx < 20);
      s_data  = 32'(idx * 256);
      s_last  = 1'b0;
      m_ready = (c >= 6);
      if (s_valid && !s_ready)
        low_seen = 1'b1;
      acc_prev = s_valid && s_ready;
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("bp_all_accepted", 32'(idx), 32'd20);
    chk("bp_tready_fell", 32'(low_seen), 32'd1);
    chk("bp_count", 32'(q0.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("bp_q%0d", i), 32'(qget(i)), 32'(i * 4));

    // DECIM=1: no bubbles after the stall is released
    idx = 0;
    acc_prev = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (acc_prev)
        idx++;
      s1_valid = (idx < 10);
      s1_data  = 32'(idx * 256);
      m1_ready = (c >= 4);
      if (c == 4)
        chk("d1_pre_release", 32'(q1.size()), 32'd0);
      if (c == 14)
        chk("d1_full_rate", 32'(q1.size()), 32'd10);
      acc_prev = s1_valid && s1_ready;
      @(negedge clk);
    end
    s1_valid = 1'b0;
    for (int i = 0; i < 10; i++)
      chk($sformatf("d1_q%0d", i), 32'(q1get(i)), 32'(i));

    // Reset with both entries full
    q0.delete();
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      send(32'(k * 256), 1'b0);
    s_valid = 1'b0;
    chk("full_tready", 32'(s_ready), 32'd0);
    chk("full_valid", 32'(m_valid), 32'd1);
    rst_in = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    chk("mrst_valid", 32'(m_valid), 32'd0);
    chk("mrst_tready", 32'(s_ready), 32'd0);
    m_ready = 1'b1;
    send(32'(5 * 256), 1'b0);
    chk("mrst_phase0_valid", 32'(m_valid), 32'd1);
    chk("mrst_phase0_data", 32'(m_data), 32'd5);
    idle(3);
    chk("mrst_count", 32'(q0.size()), 32'd1);
    chk("mrst_q0", 32'(qget(0)), 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
